// File: rtl/native_axis_pkg.sv
// ---------------------------------------------------------------------------
// native_axis_pkg
// Shared constants and helpers for the native-FIFO to AXI-Stream adapter.
//   - RD_LATENCY_MIN / RD_LATENCY_MAX : supported upstream FIFO read latencies
//   - TLAST_DISABLE                   : PKT_LEN value that turns framing off
//   - clog2()                         : pointer / counter width helper
//   - rd_latency_legal()              : range check used by the parameter assertion
// ---------------------------------------------------------------------------
package native_axis_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // A packet length of zero means "one endless stream": TLAST never asserts.
  localparam int TLAST_DISABLE = 0;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = 1; v < value; v = v << 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/axis_out_buf.sv
// ---------------------------------------------------------------------------
// axis_out_buf
// Small circular buffer holding {tlast, tdata} entries between the FIFO read
// pipe and the AXI-Stream output. Pointers carry one extra MSB so that a full
// buffer (same index, different lap) is distinguishable from an empty one.
// Storage is registered and cleared on reset, so the head entry presented on
// dout reads as zero straight out of reset.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push, din  : write strobe and entry to store at the tail
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry
//   empty/full : occupancy flags
//   count      : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_out_buf
  import native_axis_pkg::*;
#(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index on a different lap means every slot is occupied.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A push into a full buffer is only accepted when the head leaves in the
  // same cycle; the owner is expected never to rely on that.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[PTR_W-1:0]];

  // Pointer bookkeeping: push and pop in the same cycle both advance, so the
  // occupancy stays unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage. Cleared on reset so the output data/last read zero while
  // the buffer has never been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/native_fifo_to_axis.sv
// ---------------------------------------------------------------------------
// native_fifo_to_axis
// Drains a standard-read native FIFO (data valid RD_LATENCY cycles after
// rd_en) and presents it as an AXI-Stream master with TLAST framing every
// PKT_LEN beats (PKT_LEN = 0 disables TLAST).
//
// Reads are issued on credit: a read is only started when the output buffer
// has room for it counting every read still in flight, so returning data is
// always accepted and no word is lost or duplicated whatever tready does.
// The read decision never looks at tready, keeping the FIFO side free of any
// combinational path from the downstream consumer.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset (sync release expected)
//   fifo_empty     : upstream FIFO empty flag
//   fifo_rd_en     : upstream FIFO read strobe
//   fifo_dout      : upstream FIFO read data
//   m_axis_tvalid  : stream valid (buffer not empty)
//   m_axis_tready  : stream ready
//   m_axis_tdata   : stream data (head of buffer)
//   m_axis_tlast   : last beat of a PKT_LEN packet
// ---------------------------------------------------------------------------
module native_fifo_to_axis
  import native_axis_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4,
  parameter int PKT_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast
);

  localparam int  PTR_W    = clog2(BUF_DEPTH);
  localparam int  CRED_W   = PTR_W + 2;
  localparam int  CNT_W    = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;
  localparam bit  TLAST_EN = (PKT_LEN != TLAST_DISABLE);
  localparam logic [CNT_W-1:0] LAST_BEAT = TLAST_EN ? CNT_W'(PKT_LEN - 1) : '0;
  localparam logic [CRED_W-1:0] CREDITS  = CRED_W'(BUF_DEPTH);

  logic                  running;
  logic [RD_LATENCY-1:0] pipe;
  logic [CRED_W-1:0]     inflight;
  logic [CRED_W-1:0]     committed;
  logic                  push;
  logic                  pop;
  logic                  push_last;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_W:0]       buf_dout;
  logic                  buf_empty;
  logic                  buf_full;
  logic [PTR_W:0]        buf_count;

  // Goes high on the first edge after reset release, so no read can be
  // started while reset is held or on the release edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  // Number of reads whose data has not yet landed in the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CRED_W'(pipe[i]);
    end
  end

  // Credit check: buffered words plus words on their way must leave a free
  // slot. Pops in this cycle are deliberately not credited so that tready has
  // no path to fifo_rd_en.
  assign committed  = CRED_W'(buf_count) + inflight;
  assign fifo_rd_en = running && !fifo_empty && (committed < CREDITS);

  // In-flight pipe: bit i set means a read issued i+1 cycles ago. The top bit
  // marks the cycle in which fifo_dout carries that read's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign push = pipe[RD_LATENCY-1];

  // TLAST is decided when a word enters the buffer; since beats leave in the
  // same order they enter, this equals counting handshakes, and the stored
  // flag cannot change while the beat waits under backpressure.
  assign push_last = TLAST_EN && (beat_cnt == LAST_BEAT);

  // Push-side beat counter, wrapping after the last beat of each packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (push) begin
      if (push_last || !TLAST_EN) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  axis_out_buf #(
    .WIDTH (DATA_W + 1),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({push_last, fifo_dout}),
    .pop   (pop),
    .dout  (buf_dout),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  assign m_axis_tvalid = !buf_empty;
  assign m_axis_tdata  = buf_dout[DATA_W-1:0];
  assign m_axis_tlast  = buf_dout[DATA_W];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // The credit rule makes a push into a full buffer impossible; flag it in
  // simulation if that ever stops being true.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && buf_full));

  a_params_legal : assert property (@(posedge clk)
    rd_latency_legal(RD_LATENCY) && (BUF_DEPTH >= RD_LATENCY + 2) &&
    ((BUF_DEPTH & (BUF_DEPTH - 1)) == 0));

endmodule

// File: tb/tb_native_fifo_to_axis.sv
// ---------------------------------------------------------------------------
// tb_native_fifo_to_axis
// Two adapters run side by side on identical stimulus:
//   instance 0 : RD_LATENCY=1, BUF_DEPTH=4, PKT_LEN=16
//   instance 1 : RD_LATENCY=2, BUF_DEPTH=4, PKT_LEN=0 (no TLAST)
// Each has its own behavioural native FIFO and its own expected-beat queue.
// Words to send are appended to a shared source list; every FIFO model picks
// them up, and each queued word's expected TLAST comes from its position
// since reset. Per-instance monitors pop and compare on every handshake.
// ---------------------------------------------------------------------------
module tb_native_fifo_to_axis;

  localparam int DATA_W    = 64;
  localparam int BUF_DEPTH = 4;
  localparam int N_DUT     = 2;
  localparam int LAT0      = 1;
  localparam int LAT1      = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tready;
  logic [N_DUT-1:0]  rd_en;
  logic [N_DUT-1:0]  tvalid;
  logic [N_DUT-1:0]  tlast;
  logic [DATA_W-1:0] tdata [N_DUT];

  logic [DATA_W-1:0] src [$];
  bit                gap_mode;
  bit                rand_ready;
  bit                ready_fixed;
  int                checks;
  int                errors;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Appends n words to the source list: sequential from base, or random.
  task automatic applyStimulus(input int n, input bit random_vals,
                               input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      if (random_vals) src.push_back({$urandom, $urandom});
      else             src.push_back(base + DATA_W'(i));
    end
  endtask

  // Waits for n beats on every instance (bounded). Optionally checks that the
  // burst started and ended on the exact cycles a full-rate stream implies.
  task automatic waitBeats(input string name, input int n, input int budget,
                           input bit check_timing, output int tlast1_seen);
    int cnt   [N_DUT];
    int first [N_DUT];
    int last  [N_DUT];
    int lat   [N_DUT];
    int cyc;
    lat[0] = LAT0;
    lat[1] = LAT1;
    cyc = 0;
    tlast1_seen = 0;
    for (int g = 0; g < N_DUT; g++) begin
      cnt[g] = 0; first[g] = -1; last[g] = -1;
    end
    while ((cnt[0] < n || cnt[1] < n) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < N_DUT; g++) begin
        if (tvalid[g] && tready) begin
          if (first[g] < 0) first[g] = cyc;
          last[g] = cyc;
          cnt[g]++;
          if (g == 1 && tlast[1]) tlast1_seen++;
        end
      end
    end
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("%s_beats%0d", name, g), DATA_W'(cnt[g]), DATA_W'(n));
      if (check_timing) begin
        checkOutput($sformatf("%s_first_cycle%0d", name, g), DATA_W'(first[g]),
                    DATA_W'(lat[g] + 3));
        checkOutput($sformatf("%s_last_cycle%0d", name, g), DATA_W'(last[g]),
                    DATA_W'(n + lat[g] + 2));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single writer of tready: random or fixed level, updated after each edge.
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  for (genvar g = 0; g < N_DUT; g++) begin : g_inst
    localparam int LAT  = (g == 0) ? LAT0 : LAT1;
    localparam int PLEN = (g == 0) ? 16 : 0;
    localparam int PDIV = (PLEN == 0) ? 1 : PLEN;

    logic              fifo_empty;
    logic [DATA_W-1:0] dstage [LAT];
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] fifo_q [$];
    beat_t             exp_q [$];
    int                loaded;
    int                push_idx;

    assign fifo_dout = dstage[LAT-1];

    native_fifo_to_axis #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (LAT),
      .BUF_DEPTH  (BUF_DEPTH),
      .PKT_LEN    (PLEN)
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (rd_en[g]),
      .fifo_dout     (fifo_dout),
      .m_axis_tvalid (tvalid[g]),
      .m_axis_tready (tready),
      .m_axis_tdata  (tdata[g]),
      .m_axis_tlast  (tlast[g])
    );

    // Native FIFO model: a read pops the head, which appears on fifo_dout LAT
    // cycles later; otherwise junk flows down the read pipe. It is flushed by
    // reset along with the adapter.
    initial begin
      logic [DATA_W-1:0] word;
      beat_t             e;
      fifo_empty = 1'b1;
      for (int i = 0; i < LAT; i++) dstage[i] = '0;
      loaded   = 0;
      push_idx = 0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          fifo_q.delete();
          exp_q.delete();
          loaded   = src.size();
          push_idx = 0;
          fifo_empty <= 1'b1;
          for (int i = 0; i < LAT; i++) dstage[i] <= '0;
        end else begin
          word = {$urandom, $urandom};
          if (rd_en[g]) begin
            checkOutput($sformatf("rd_en_while_empty%0d", g), DATA_W'(fifo_empty), '0);
            if (fifo_q.size() > 0) word = fifo_q.pop_front();
          end
          for (int i = LAT - 1; i > 0; i--) dstage[i] <= dstage[i-1];
          dstage[0] <= word;
          while (loaded < src.size()) begin
            e.data = src[loaded];
            e.last = (PLEN != 0) && ((push_idx % PDIV) == PDIV - 1);
            fifo_q.push_back(src[loaded]);
            exp_q.push_back(e);
            loaded++;
            push_idx++;
          end
          fifo_empty <= (fifo_q.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));
        end
      end
    end

    // Monitor: compares every handshake against the expected queue and checks
    // that a stalled beat holds valid, data and last until it is taken.
    initial begin
      bit                hold;
      logic [DATA_W-1:0] hold_data;
      logic              hold_last;
      beat_t             e;
      hold = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold = 1'b0;
        end else begin
          if (hold) begin
            checkOutput($sformatf("stable_valid%0d", g), DATA_W'(tvalid[g]), DATA_W'(1));
            checkOutput($sformatf("stable_data%0d", g), tdata[g], hold_data);
            checkOutput($sformatf("stable_last%0d", g), DATA_W'(tlast[g]), DATA_W'(hold_last));
          end
          if (tvalid[g] && tready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_beat%0d: got data 0x%0h, want no beat", g, tdata[g]);
            end else begin
              e = exp_q.pop_front();
              checkOutput($sformatf("beat_data%0d", g), tdata[g], e.data);
              checkOutput($sformatf("beat_last%0d", g), DATA_W'(tlast[g]), DATA_W'(e.last));
            end
            hold = 1'b0;
          end else begin
            hold      = tvalid[g];
            hold_data = tdata[g];
            hold_last = tlast[g];
          end
        end
      end
    end
  end

  initial begin
    int rd_cnt [N_DUT];
    int tl1;
    checks      = 0;
    errors      = 0;
    gap_mode    = 1'b0;
    rand_ready  = 1'b0;
    ready_fixed = 1'b0;
    rst_n       = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("reset_tvalid%0d", g), DATA_W'(tvalid[g]), '0);
      checkOutput($sformatf("reset_rd_en%0d", g), DATA_W'(rd_en[g]), '0);
      checkOutput($sformatf("reset_tlast%0d", g), DATA_W'(tlast[g]), '0);
      checkOutput($sformatf("reset_tdata%0d", g), tdata[g], '0);
    end
    rst_n = 1'b1;
    ready_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0..19 at full rate, TLAST on value 15 for instance 0.
    applyStimulus(20, 1'b0, '0);
    waitBeats("stream20", 20, 200, 1'b1, tl1);
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("idle_rd_en%0d", g), DATA_W'(rd_en[g]), '0);
    end

    // Backpressure: only BUF_DEPTH reads may be issued, head stays at 0.
    ready_fixed = 1'b0;
    applyStimulus(10, 1'b0, '0);
    for (int g = 0; g < N_DUT; g++) rd_cnt[g] = 0;
    repeat (12) begin
      @(negedge clk);
      for (int g = 0; g < N_DUT; g++) rd_cnt[g] += int'(rd_en[g]);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("bp_reads%0d", g), DATA_W'(rd_cnt[g]), DATA_W'(BUF_DEPTH));
      checkOutput($sformatf("bp_tvalid%0d", g), DATA_W'(tvalid[g]), DATA_W'(1));
      checkOutput($sformatf("bp_tdata%0d", g), tdata[g], '0);
    end
    ready_fixed = 1'b1;
    waitBeats("bp_release", 10, 200, 1'b0, tl1);

    // Random tready and FIFO empty gaps over a long random stream.
    gap_mode   = 1'b1;
    rand_ready = 1'b1;
    applyStimulus(10000, 1'b1, '0);
    waitBeats("random", 10000, 80000, 1'b0, tl1);
    gap_mode   = 1'b0;
    rand_ready = 1'b0;
    ready_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a stalled stream.
    applyStimulus(8, 1'b0, DATA_W'(32'hA0));
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("pre_reset_tvalid%0d", g), DATA_W'(tvalid[g]), DATA_W'(1));
    end
    rst_n = 1'b0;
    #2;
    for (int g = 0; g < N_DUT; g++) begin
      checkOutput($sformatf("midreset_tvalid%0d", g), DATA_W'(tvalid[g]), '0);
      checkOutput($sformatf("midreset_rd_en%0d", g), DATA_W'(rd_en[g]), '0);
      checkOutput($sformatf("midreset_tlast%0d", g), DATA_W'(tlast[g]), '0);
      checkOutput($sformatf("midreset_tdata%0d", g), tdata[g], '0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fresh stream after reset: full rate, framing restarts at beat 0.
    applyStimulus(100, 1'b0, DATA_W'(32'h1000));
    waitBeats("post_reset100", 100, 400, 1'b1, tl1);
    checkOutput("no_tlast_pktlen0", DATA_W'(tl1), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
